access_sequencer: RTL and testbench
===================================

ACCESS_SEQUENCER -- requirements
Module: access_sequencer

Interface
REQ-001 Parameter GRANT_CYCLES, default 8: cycles the grant outputs stay asserted after a successful check (legal range 1..255).
REQ-002 Parameter MAX_FAILS, default 3: consecutive denials that trigger lockout (legal range 1..15).
REQ-003 Parameter LOCK_CYCLES, default 16: lockout duration in cycles (legal range 1..255).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 req  input  1  access request; sampled only in IDLE.
REQ-007 user_code  input  3  requesting user level.
REQ-008 func_code  input  3  requested function.
REQ-009 perm  input  3  permission vector returned by the authentication stage for (U_out, F_out).
REQ-010 U_out  output  3  latched user code driven to the authentication stage.
REQ-011 F_out  output  3  latched function code driven to the authentication stage.
REQ-012 ack  output  1  one-cycle pulse: request accepted.
REQ-013 grant  output  3  registered permission vector, valid while granting.
REQ-014 deny  output  1  one-cycle pulse: request refused.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 lockout  output  1  high while in LOCK.
REQ-017 done  output  1  one-cycle pulse when a grant window ends.

Function
REQ-018 States: IDLE, CHECK, GRANT, LOCK; encoding from the shared package.
REQ-019 IDLE with req=1: latch user_code/func_code into U_out/F_out, pulse ack, go to CHECK next cycle.
REQ-020 req while busy is ignored; no queuing, no ack.
REQ-021 CHECK lasts exactly one cycle; perm is sampled at its end (combinational path perm = f(U_out, F_out) settled).
REQ-022 perm != 3'b000: grant <= perm, fail counter cleared, timer loaded GRANT_CYCLES, go to GRANT.
REQ-023 perm == 3'b000: pulse deny, fail counter +1; if counter reaches MAX_FAILS go to LOCK (timer loaded LOCK_CYCLES, counter cleared), else IDLE.
REQ-024 GRANT: grant held constant; timer decrements each cycle; at timer==1 pulse done, grant <= 0, go to IDLE; grant window is exactly GRANT_CYCLES cycles.
REQ-025 LOCK: lockout=1 for exactly LOCK_CYCLES cycles, then IDLE; req ignored throughout.
REQ-026 Latency req -> ack: 1 cycle; req -> grant or deny: 2 cycles.
REQ-027 Fail counter saturates at MAX_FAILS; never wraps.
REQ-028 U_out/F_out hold their last latched values outside IDLE acceptance.

Reset
REQ-029 rst_n low, at any time including mid-GRANT or mid-LOCK: state IDLE, U_out/F_out/grant = 0, ack/deny/done/lockout/busy = 0, timer and fail counter = 0.
REQ-030 First request is accepted on the first rising edge with rst_n high and req high.

Configuration
REQ-031 Macro ACCESS_LOCKOUT_EN defined: lockout behaviour per REQ-023/REQ-025.
REQ-032 Macro absent: LOCK state and fail counter not built; lockout tied 0; every denial returns to IDLE.

Structure
REQ-033 Package access_pkg holds state typedef/encoding, default GRANT_CYCLES/MAX_FAILS/LOCK_CYCLES, and the 3'b000 no-permission constant.
REQ-034 One sub-module, access_timer: 8-bit loadable down-counter with load, enable, and expire (count==1) outputs, shared by GRANT and LOCK.

Verification
REQ-035 Reset, then req with user_code=3'b001, func_code=3'b000, perm model returning 3'b011 -> ack at cycle 1, grant=3'b011 cycles 2..9, done pulse in cycle 9, busy low cycle 10.
REQ-036 perm forced 3'b000, three back-to-back requests (lockout on) -> three deny pulses, lockout high for 16 cycles after third, req during lockout gets no ack.
REQ-037 Same as REQ-036 without ACCESS_LOCKOUT_EN -> three denies, lockout never asserts, fourth request acked.
REQ-038 Two denials then grant then two denials -> no lockout (counter cleared by grant).
REQ-039 rst_n pulsed low mid-GRANT (cycle 5) -> grant=0 and busy=0 immediately, asynchronously; next req acked normally.
REQ-040 req held high continuously -> new ack only on the cycle after each return to IDLE.

Source files
------------

// File: rtl/access_pkg.sv
// Shared definitions for the access sequencer: state encoding, default
// timing/lockout parameters, the "no permission" code and a saturating
// fail-counter helper.
package access_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_GRANT = 2'd2,
        ST_LOCK  = 2'd3
    } state_t;

    localparam int DEF_GRANT_CYCLES = 8;
    localparam int DEF_MAX_FAILS    = 3;
    localparam int DEF_LOCK_CYCLES  = 16;

    localparam logic [2:0] NO_PERM = 3'b000;

    localparam int TIMER_W = 8;
    localparam int FAIL_W  = 4;

    // Increment a fail count but never past max_fails.
    function automatic logic [FAIL_W-1:0] fail_inc_sat(input logic [FAIL_W-1:0] cnt,
                                                       input int max_fails);
        if (int'(cnt) >= max_fails) begin
            return FAIL_W'(max_fails);
        end
        return cnt + 1'b1;
    endfunction

endpackage

// File: rtl/access_timer.sv
// 8-bit loadable down-counter shared by the grant window and the lockout
// period. expire is high while the count sits at 1, i.e. during the last
// cycle of the programmed interval.
module access_timer
    import access_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_value,
    input  logic               en,
    output logic [TIMER_W-1:0] count,
    output logic               expire
);

    logic [TIMER_W-1:0] count_reg;

    // Load has priority; otherwise count down while enabled, stopping at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (en && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign count  = count_reg;
    assign expire = (count_reg == TIMER_W'(1));

endmodule

// File: rtl/access_sequencer.sv
// Access sequencer: latches a user/function request, checks the permission
// vector returned by the authentication stage one cycle later, then either
// opens a fixed-length grant window or refuses the request.
// Optional feature: define ACCESS_LOCKOUT_EN to build the consecutive-denial
// counter and the LOCK state; without it every denial simply returns to IDLE.
module access_sequencer
    import access_pkg::*;
#(
    parameter int GRANT_CYCLES = DEF_GRANT_CYCLES,
    parameter int MAX_FAILS    = DEF_MAX_FAILS,
    parameter int LOCK_CYCLES  = DEF_LOCK_CYCLES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    input  logic [2:0] user_code,
    input  logic [2:0] func_code,
    input  logic [2:0] perm,
    output logic [2:0] U_out,
    output logic [2:0] F_out,
    output logic       ack,
    output logic [2:0] grant,
    output logic       deny,
    output logic       busy,
    output logic       lockout,
    output logic       done
);

    // Reject out-of-range configurations at elaboration time.
    if (GRANT_CYCLES < 1 || GRANT_CYCLES > 255 ||
        MAX_FAILS < 1 || MAX_FAILS > 15 ||
        LOCK_CYCLES < 1 || LOCK_CYCLES > 255) begin : g_bad_params
        $error("access_sequencer: parameter out of range");
    end

    localparam logic [TIMER_W-1:0] GRANT_LOAD   = TIMER_W'(GRANT_CYCLES);
    localparam logic               GRANT_SINGLE = (GRANT_CYCLES == 1);

    state_t             state_reg;
    logic [2:0]         u_reg;
    logic [2:0]         f_reg;
    logic [2:0]         grant_reg;
    logic               ack_reg;
    logic               deny_reg;
    logic               done_reg;
    logic               busy_reg;
    logic               perm_ok;
    logic               timer_load;
    logic               timer_en;
    logic               timer_expire;
    logic [TIMER_W-1:0] timer_load_value;
    logic [TIMER_W-1:0] timer_count;

`ifdef ACCESS_LOCKOUT_EN
    localparam logic [TIMER_W-1:0] LOCK_LOAD = TIMER_W'(LOCK_CYCLES);
    logic [FAIL_W-1:0] fail_cnt_reg;
    logic              lock_entry;
    logic              lockout_reg;
`endif

    // Decide when and with what the shared timer is loaded: the grant length
    // on a good check, the lockout length when this denial trips the limit.
    always_comb begin
        perm_ok          = (perm != NO_PERM);
        timer_load       = 1'b0;
        timer_load_value = GRANT_LOAD;
`ifdef ACCESS_LOCKOUT_EN
        lock_entry       = (({1'b0, fail_cnt_reg} + 5'd1) >= 5'(MAX_FAILS));
`endif
        if (state_reg == ST_CHECK) begin
            if (perm_ok) begin
                timer_load = 1'b1;
            end
`ifdef ACCESS_LOCKOUT_EN
            else if (lock_entry) begin
                timer_load       = 1'b1;
                timer_load_value = LOCK_LOAD;
            end
`endif
        end
        timer_en = (state_reg == ST_GRANT) || (state_reg == ST_LOCK);
    end

    access_timer u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (timer_load),
        .load_value (timer_load_value),
        .en         (timer_en),
        .count      (timer_count),
        .expire     (timer_expire)
    );

    // Main sequencer FSM; every output is a register. done is set one edge
    // early so that it lines up with the final cycle of the grant window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            u_reg        <= '0;
            f_reg        <= '0;
            grant_reg    <= '0;
            ack_reg      <= 1'b0;
            deny_reg     <= 1'b0;
            done_reg     <= 1'b0;
            busy_reg     <= 1'b0;
`ifdef ACCESS_LOCKOUT_EN
            fail_cnt_reg <= '0;
            lockout_reg  <= 1'b0;
`endif
        end else begin
            ack_reg  <= 1'b0;
            deny_reg <= 1'b0;
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (req) begin
                        u_reg     <= user_code;
                        f_reg     <= func_code;
                        ack_reg   <= 1'b1;
                        busy_reg  <= 1'b1;
                        state_reg <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (perm_ok) begin
                        grant_reg <= perm;
                        done_reg  <= GRANT_SINGLE;
                        state_reg <= ST_GRANT;
`ifdef ACCESS_LOCKOUT_EN
                        fail_cnt_reg <= '0;
`endif
                    end else begin
                        deny_reg <= 1'b1;
`ifdef ACCESS_LOCKOUT_EN
                        if (lock_entry) begin
                            fail_cnt_reg <= '0;
                            lockout_reg  <= 1'b1;
                            state_reg    <= ST_LOCK;
                        end else begin
                            fail_cnt_reg <= fail_inc_sat(fail_cnt_reg, MAX_FAILS);
                            busy_reg     <= 1'b0;
                            state_reg    <= ST_IDLE;
                        end
`else
                        busy_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
`endif
                    end
                end
                ST_GRANT: begin
                    if (timer_count == TIMER_W'(2)) begin
                        done_reg <= 1'b1;
                    end
                    if (timer_expire) begin
                        grant_reg <= '0;
                        busy_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end
`ifdef ACCESS_LOCKOUT_EN
                ST_LOCK: begin
                    if (timer_expire) begin
                        lockout_reg <= 1'b0;
                        busy_reg    <= 1'b0;
                        state_reg   <= ST_IDLE;
                    end
                end
`endif
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign U_out = u_reg;
    assign F_out = f_reg;
    assign ack   = ack_reg;
    assign grant = grant_reg;
    assign deny  = deny_reg;
    assign done  = done_reg;
    assign busy  = busy_reg;
`ifdef ACCESS_LOCKOUT_EN
    assign lockout = lockout_reg;
`else
    assign lockout = 1'b0;
`endif

endmodule

// File: tb/tb_access_sequencer.sv
// Scoreboard bench for access_sequencer. A cycle-arithmetic reference model
// predicts ack/deny/done events and per-cycle grant/lockout/busy/latched codes
// for every request issued; a negedge monitor compares what the DUT shows.
module tb_access_sequencer;

    localparam int GC   = 8;
    localparam int MF   = 3;
    localparam int LC   = 16;
    localparam int MAXC = 3000;

    localparam int EV_ACK  = 0;
    localparam int EV_DENY = 1;
    localparam int EV_DONE = 2;

    typedef struct {
        int         cyc;
        int         kind;
        logic [5:0] data;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req = 1'b0;
    logic [2:0] user_code = 3'd0;
    logic [2:0] func_code = 3'd0;
    logic [2:0] perm;
    logic [2:0] U_out;
    logic [2:0] F_out;
    logic       ack;
    logic [2:0] grant;
    logic       deny;
    logic       busy;
    logic       lockout;
    logic       done;

    // authentication stage model: permission looked up from the latched codes
    logic [2:0] perm_tab [64];
    assign perm = perm_tab[{U_out, F_out}];

    access_sequencer #(
        .GRANT_CYCLES (GC),
        .MAX_FAILS    (MF),
        .LOCK_CYCLES  (LC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .user_code (user_code),
        .func_code (func_code),
        .perm      (perm),
        .U_out     (U_out),
        .F_out     (F_out),
        .ack       (ack),
        .grant     (grant),
        .deny      (deny),
        .busy      (busy),
        .lockout   (lockout),
        .done      (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int  total = 0;
    int  bad = 0;
    bit  mon_en = 1'b0;
    int  free_cyc = 0;
    int  fails = 0;
    ev_t ev_q[$];

    logic [2:0] e_grant [MAXC];
    bit         e_lock  [MAXC];
    bit         e_busy  [MAXC];
    logic [5:0] e_uf    [MAXC];

    function automatic string kname(input int k);
        if (k == EV_ACK) return "ack";
        if (k == EV_DENY) return "deny";
        return "done";
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic push_ev(input int c, input int k, input logic [5:0] d);
        ev_t e;
        e.cyc = c; e.kind = k; e.data = d;
        ev_q.push_back(e);
    endtask

    // Reference model: a request in cycle c is taken if the sequencer is
    // free by then; everything else follows from fixed cycle offsets.
    task automatic model_req(input int c, input logic [2:0] u, input logic [2:0] f);
        logic [2:0] p;
        bit         lock_now;
        if (c < free_cyc) return;
        p = perm_tab[{u, f}];
        push_ev(c + 1, EV_ACK, {u, f});
        for (int k = c + 1; k < MAXC; k++) e_uf[k] = {u, f};
        if (p != 3'b000) begin
            for (int k = c + 1; k <= c + 1 + GC && k < MAXC; k++) e_busy[k] = 1'b1;
            for (int k = c + 2; k <= c + 1 + GC && k < MAXC; k++) e_grant[k] = p;
            push_ev(c + 1 + GC, EV_DONE, {3'b000, p});
            fails    = 0;
            free_cyc = c + 2 + GC;
        end else begin
            push_ev(c + 2, EV_DENY, 6'd0);
            fails++;
            lock_now = 1'b0;
`ifdef ACCESS_LOCKOUT_EN
            lock_now = (fails >= MF);
`endif
            if (lock_now) begin
                for (int k = c + 1; k <= c + 1 + LC && k < MAXC; k++) e_busy[k] = 1'b1;
                for (int k = c + 2; k <= c + 1 + LC && k < MAXC; k++) e_lock[k] = 1'b1;
                fails    = 0;
                free_cyc = c + 2 + LC;
            end else begin
                if (c + 1 < MAXC) e_busy[c + 1] = 1'b1;
                free_cyc = c + 2;
            end
        end
    endtask

    // One stimulus cycle; entered and left just after a rising edge.
    task automatic drive(input bit r, input logic [2:0] u, input logic [2:0] f);
        req = r; user_code = u; func_code = f;
        if (r) model_req(cyc, u, f);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        while (cyc < free_cyc) drive(1'b0, 3'($urandom), 3'($urandom));
    endtask

    task automatic see_event(input int kind, input logic [5:0] data);
        ev_t e;
        total++;
        if (ev_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_%s cyc=%0d got=%0h required=no_event", kname(kind), cyc, data);
        end else begin
            e = ev_q.pop_front();
            if (e.kind != kind || e.cyc != cyc || e.data != data) begin
                bad++;
                $display("FAIL event_%s got=(%s,cyc %0d,%0h) required=(%s,cyc %0d,%0h)",
                         kname(kind), kname(kind), cyc, data, kname(e.kind), e.cyc, e.data);
            end else begin
                $display("txn %s cyc=%0d data=%0h", kname(kind), cyc, data);
            end
        end
    endtask

    // Monitor: compare events against the scoreboard and per-cycle state.
    always @(negedge clk) begin
        if (mon_en) begin
            while (ev_q.size() > 0 && ev_q[0].cyc < cyc) begin
                total++;
                bad++;
                $display("FAIL missed_%s got=no_event required=cyc %0d now=%0d",
                         kname(ev_q[0].kind), ev_q[0].cyc, cyc);
                void'(ev_q.pop_front());
            end
            if (ack)  see_event(EV_ACK, {U_out, F_out});
            if (deny) see_event(EV_DENY, 6'd0);
            if (done) see_event(EV_DONE, {3'b000, grant});
            if (cyc < MAXC)
                check("cycle_state", {21'd0, grant, lockout, busy, U_out, F_out},
                      {21'd0, e_grant[cyc], e_lock[cyc], e_busy[cyc], e_uf[cyc]});
        end
    end

    initial begin
        int c0;
        for (int k = 0; k < MAXC; k++) begin
            e_grant[k] = '0; e_lock[k] = 1'b0; e_busy[k] = 1'b0; e_uf[k] = '0;
        end
        for (int k = 0; k < 64; k++) perm_tab[k] = 3'b000;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {20'd0, U_out, F_out, grant, ack, deny, done, lockout, busy}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        free_cyc = cyc;
        mon_en = 1'b1;

        // single granted request right after reset
        perm_tab[{3'b001, 3'b000}] = 3'b011;
        drive(1'b1, 3'b001, 3'b000);
        repeat (12) drive(1'b0, 3'd0, 3'd0);

        // all denials with req held high: lockout (if built) and re-accept timing
        for (int k = 0; k < 64; k++) perm_tab[k] = 3'b000;
        for (int i = 0; i < 60; i++) drive(1'b1, 3'($urandom), 3'($urandom));
        drive(1'b0, 3'd0, 3'd0);
        wait_idle();

        // two denials, a grant, two denials: the grant clears the count
        perm_tab[{3'b111, 3'b111}] = 3'b101;
        drive(1'b1, 3'd0, 3'd1); wait_idle();
        drive(1'b1, 3'd0, 3'd2); wait_idle();
        drive(1'b1, 3'd7, 3'd7); wait_idle();
        drive(1'b1, 3'd2, 3'd0); wait_idle();
        drive(1'b1, 3'd3, 3'd0); wait_idle();
        repeat (3) drive(1'b0, 3'd0, 3'd0);

        // asynchronous reset in the middle of a grant window
        c0 = cyc;
        drive(1'b1, 3'd7, 3'd7);
        while (cyc < c0 + 5) drive(1'b0, 3'd0, 3'd0);
        #1;
        rst_n = 1'b0;
        mon_en = 1'b0;
        #1;
        check("rst_async", {21'd0, grant, busy, lockout, U_out, F_out}, 32'd0);
        ev_q.delete();
        for (int k = cyc; k < MAXC; k++) begin
            e_grant[k] = '0; e_lock[k] = 1'b0; e_busy[k] = 1'b0; e_uf[k] = '0;
        end
        fails = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        free_cyc = cyc;
        mon_en = 1'b1;
        drive(1'b1, 3'd7, 3'd7);
        wait_idle();

        // randomized traffic against a random permission table
        for (int k = 0; k < 64; k++)
            perm_tab[k] = ($urandom_range(0, 9) < 4) ? 3'b000 : 3'($urandom_range(1, 7));
        for (int i = 0; i < 700; i++)
            drive(1'($urandom_range(0, 1)), 3'($urandom), 3'($urandom));

        // drain
        drive(1'b0, 3'd0, 3'd0);
        wait_idle();
        repeat (4) drive(1'b0, 3'd0, 3'd0);
        check("queue_empty", ev_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
